// File: rtl/cpu_defs.sv
// Shared CPU definitions: the regfile write request and the writeback
// arbiter requester indices.
package cpu_defs;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wrdata;
  } regs_wreq_t;

  localparam int unsigned WB_REQ_PIPE     = 0;
  localparam int unsigned WB_REQ_MULDIV   = 1;
  localparam int unsigned WB_REQ_UNCACHED = 2;

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin pick over writeback requesters 1..N_REQ-1. It grants up to
// free_ports candidates and skips any waddr that is already being written.
module wb_rr_pick #(
  parameter  int unsigned N_REQ       = 3,
  parameter  int unsigned WRITE_PORTS = 1,
  localparam int unsigned IW          = $clog2(N_REQ),
  localparam int unsigned PW          = $clog2(WRITE_PORTS + 1)
) (
  input  logic [N_REQ-1:0]            elig,
  input  logic [N_REQ-1:0][4:0]       cand_addr,
  input  logic [IW-1:0]               rr_ptr,
  input  logic [PW-1:0]               free_ports,
  input  logic [WRITE_PORTS-1:0]      taken_vld,
  input  logic [WRITE_PORTS-1:0][4:0] taken_addr,
  output logic [N_REQ-1:0]            grant,
  output logic                        any_grant,
  output logic [IW-1:0]               last_idx
);

  always_comb begin
    logic [WRITE_PORTS-1:0]      seen_vld;
    logic [WRITE_PORTS-1:0][4:0] seen_addr;
    int unsigned                 slot;
    int unsigned                 t;
    logic [IW-1:0]               c;
    logic                        hit;

    grant     = '0;
    any_grant = 1'b0;
    last_idx  = '0;
    seen_vld  = taken_vld;
    seen_addr = taken_addr;
    slot      = WRITE_PORTS - 32'(free_ports);

    // Walk the ring rr_ptr .. N_REQ-1, 1 .. rr_ptr-1; index 0 never takes part.
    for (int unsigned k = 0; k < N_REQ - 1; k++) begin
      t = 32'(rr_ptr) + k;
      if (t >= N_REQ) t = t - (N_REQ - 1);
      c = IW'(t);

      hit = 1'b0;
      for (int unsigned p = 0; p < WRITE_PORTS; p++)
        if (seen_vld[p] && seen_addr[p] == cand_addr[c]) hit = 1'b1;

      if (elig[c] && slot < WRITE_PORTS && !hit) begin
        grant[c]  = 1'b1;
        any_grant = 1'b1;
        last_idx  = c;
        for (int unsigned p = 0; p < WRITE_PORTS; p++)
          if (p == slot) begin
            seen_vld[p]  = 1'b1;
            seen_addr[p] = cand_addr[c];
          end
        slot = slot + 1;
      end
    end
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter: shares the regfile write ports between the in-order pipe
// (fixed priority), mul/div and uncached loads (round-robin, starvation guard).
module regs_wb_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned WRITE_PORTS = 1,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic       [N_REQ-1:0]       req_valid,
  input  regs_wreq_t [N_REQ-1:0]       req_wreq,
  output logic       [N_REQ-1:0]       req_ready,
  output regs_wreq_t [WRITE_PORTS-1:0] regs_wreq,
  output logic                         busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned PW = $clog2(WRITE_PORTS + 1);

  logic [IW-1:0]                 rr_ptr;
  logic [N_REQ-1:0][3:0]         wait_cnt;

  logic [N_REQ-1:0]              live;
  logic [N_REQ-1:0][4:0]         cand_addr;
  logic [N_REQ-1:0]              grant_pre;
  logic [N_REQ-1:0]              rr_elig;
  logic [N_REQ-1:0]              rr_grant;
  logic [N_REQ-1:0]              grant;
  logic [WRITE_PORTS-1:0]        pre_vld;
  logic [WRITE_PORTS-1:0][4:0]   pre_addr;
  logic [WRITE_PORTS-1:0][IW-1:0] pre_src;
  logic [PW-1:0]                 free_ports;
  logic                          rr_any;
  logic [IW-1:0]                 rr_last;
  regs_wreq_t [WRITE_PORTS-1:0]  wreq_d;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      live[i]      = req_valid[i] && req_wreq[i].we && (req_wreq[i].waddr != '0);
      cand_addr[i] = req_wreq[i].waddr;
    end
  end

  // Starved requesters and requester 0. The pass j == N_REQ stands for
  // requester 0 so it is considered right after the starved ones.
  always_comb begin
    int unsigned   slot;
    logic [IW-1:0] c;
    logic          hit;

    grant_pre = '0;
    pre_vld   = '0;
    pre_addr  = '0;
    pre_src   = '0;
    slot      = 0;

    for (int unsigned j = 1; j <= N_REQ; j++) begin
      c = (j == N_REQ) ? IW'(WB_REQ_PIPE) : IW'(j);

      hit = 1'b0;
      for (int unsigned p = 0; p < WRITE_PORTS; p++)
        if (pre_vld[p] && pre_addr[p] == cand_addr[c]) hit = 1'b1;

      if (live[c] && (c == '0 || wait_cnt[c] >= 4'(MAX_WAIT)) &&
          slot < WRITE_PORTS && !hit) begin
        grant_pre[c] = 1'b1;
        for (int unsigned p = 0; p < WRITE_PORTS; p++)
          if (p == slot) begin
            pre_vld[p]  = 1'b1;
            pre_addr[p] = cand_addr[c];
            pre_src[p]  = c;
          end
        slot = slot + 1;
      end
    end
    free_ports = PW'(WRITE_PORTS - slot);
  end

  always_comb begin
    rr_elig    = live & ~grant_pre;
    rr_elig[0] = 1'b0;
  end

  wb_rr_pick #(
    .N_REQ       (N_REQ),
    .WRITE_PORTS (WRITE_PORTS)
  ) u_rr_pick (
    .elig       (rr_elig),
    .cand_addr  (cand_addr),
    .rr_ptr     (rr_ptr),
    .free_ports (free_ports),
    .taken_vld  (pre_vld),
    .taken_addr (pre_addr),
    .grant      (rr_grant),
    .any_grant  (rr_any),
    .last_idx   (rr_last)
  );

  assign grant     = grant_pre | rr_grant;
  assign req_ready = (grant | (req_valid & ~live)) & {N_REQ{~rst}};
  assign busy      = |(live & ~req_ready);

  // Port order follows grant order: earlier stages first, then rr grants in ring order.
  always_comb begin
    int unsigned   slot;
    int unsigned   t;
    logic [IW-1:0] c;

    wreq_d = '0;
    slot   = 0;
    for (int unsigned p = 0; p < WRITE_PORTS; p++)
      if (pre_vld[p]) begin
        wreq_d[p] = req_wreq[pre_src[p]];
        slot      = slot + 1;
      end

    for (int unsigned k = 0; k < N_REQ - 1; k++) begin
      t = 32'(rr_ptr) + k;
      if (t >= N_REQ) t = t - (N_REQ - 1);
      c = IW'(t);
      if (rr_grant[c]) begin
        for (int unsigned p = 0; p < WRITE_PORTS; p++)
          if (p == slot) wreq_d[p] = req_wreq[c];
        slot = slot + 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_wreq <= '0;
      rr_ptr    <= IW'(1);
      wait_cnt  <= '0;
    end else begin
      regs_wreq <= wreq_d;
      if (rr_any)
        rr_ptr <= (rr_last == IW'(N_REQ - 1)) ? IW'(1) : rr_last + IW'(1);
      for (int unsigned j = 1; j < N_REQ; j++) begin
        if (!req_valid[j] || grant[j])
          wait_cnt[j] <= '0;
        else if (live[j] && wait_cnt[j] != 4'hf)
          wait_cnt[j] <= wait_cnt[j] + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: one instance with one write port and
// one with two, both fed the same stimulus and checked against a list model.
module tb_regs_wb_arbiter;
  import cpu_defs::*;

  localparam int N  = 3;
  localparam int MW = 4;

  logic clk;
  logic rst;
  logic       [N-1:0] req_valid;
  regs_wreq_t [N-1:0] req_wreq;
  logic       [N-1:0] ready_a, ready_b;
  logic               busy_a, busy_b;
  regs_wreq_t [0:0]   wreq_a;
  regs_wreq_t [1:0]   wreq_b;

  regs_wb_arbiter #(.N_REQ(N), .WRITE_PORTS(1), .MAX_WAIT(MW)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wreq(req_wreq),
    .req_ready(ready_a), .regs_wreq(wreq_a), .busy(busy_a));

  regs_wb_arbiter #(.N_REQ(N), .WRITE_PORTS(2), .MAX_WAIT(MW)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wreq(req_wreq),
    .req_ready(ready_b), .regs_wreq(wreq_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] ready_a;
    logic         busy_a;
    logic [N-1:0] ready_b;
    logic         busy_b;
  } exp_c_t;

  typedef struct packed {
    regs_wreq_t wa0;
    regs_wreq_t wb0;
    regs_wreq_t wb1;
  } exp_o_t;

  exp_c_t comb_q[$];
  exp_o_t out_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: rr pointer and refusal counters.
  int m_rr[2];
  int m_wait[2][N];
  logic [N-1:0] last_rdy_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic regs_wreq_t mk(input logic we, input int addr, input logic [31:0] data);
    regs_wreq_t r;
    r.we     = we;
    r.waddr  = 5'(addr);
    r.wrdata = data;
    return r;
  endfunction

  // Builds the candidate list (starved, pipe, ring from rr) and fills ports in list order.
  task automatic model(input int inst, input int wp, output logic [N-1:0] rdy,
                       output logic bsy, output regs_wreq_t o0, output regs_wreq_t o1);
    int         order[$];
    int         used_addr[$];
    bit         live[N];
    bit         granted[N];
    regs_wreq_t outs[2];
    int         nports, last_rr, ring_start, c;
    bit         clash;

    rdy = '0; bsy = 1'b0; outs[0] = '0; outs[1] = '0;
    for (int i = 0; i < N; i++) begin
      live[i]    = req_valid[i] && req_wreq[i].we && (req_wreq[i].waddr != 0);
      granted[i] = 1'b0;
    end

    if (rst) begin
      m_rr[inst] = 1;
      for (int i = 0; i < N; i++) begin
        m_wait[inst][i] = 0;
        if (live[i]) bsy = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && !live[i]) rdy[i] = 1'b1;

      for (int j = 1; j < N; j++)
        if (live[j] && m_wait[inst][j] >= MW) order.push_back(j);
      order.push_back(0);
      ring_start = order.size();
      for (int k = 0; k < N - 1; k++)
        order.push_back(1 + (m_rr[inst] - 1 + k) % (N - 1));

      nports  = 0;
      last_rr = -1;
      for (int i = 0; i < order.size(); i++) begin
        c = order[i];
        clash = 1'b0;
        foreach (used_addr[u]) if (used_addr[u] == int'(req_wreq[c].waddr)) clash = 1'b1;
        if (live[c] && !granted[c] && nports < wp && !clash) begin
          granted[c]   = 1'b1;
          outs[nports] = req_wreq[c];
          nports++;
          used_addr.push_back(int'(req_wreq[c].waddr));
          if (i >= ring_start) last_rr = c;
        end
      end

      if (last_rr > 0) m_rr[inst] = (last_rr == N - 1) ? 1 : last_rr + 1;
      for (int j = 1; j < N; j++) begin
        if (!req_valid[j] || granted[j]) m_wait[inst][j] = 0;
        else if (live[j] && m_wait[inst][j] < 15) m_wait[inst][j]++;
      end
      for (int i = 0; i < N; i++) begin
        if (granted[i]) rdy[i] = 1'b1;
        if (live[i] && !granted[i]) bsy = 1'b1;
      end
    end
    o0 = outs[0];
    o1 = outs[1];
  endtask

  // Called with inputs settled: pushes expectations, then advances one cycle.
  task automatic step();
    exp_c_t       ec;
    exp_o_t       eo;
    logic [N-1:0] r;
    logic         b;
    regs_wreq_t   x0, x1;
    model(0, 1, r, b, x0, x1);
    ec.ready_a = r; ec.busy_a = b; eo.wa0 = x0;
    last_rdy_a = r;
    model(1, 2, r, b, x0, x1);
    ec.ready_b = r; ec.busy_b = b; eo.wb0 = x0; eo.wb1 = x1;
    comb_q.push_back(ec);
    out_q.push_back(eo);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  task automatic rand_cycles(input int n, input int p_new);
    repeat (n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_rdy_a[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(99) < p_new) begin
          req_valid[i] = 1'b1;
          req_wreq[i]  = mk($urandom_range(9) != 0, int'($urandom_range(7)), $urandom());
        end
      end
      step();
    end
  endtask

  initial begin : mon_comb
    exp_c_t e;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check("ready_a", 64'(ready_a), 64'(e.ready_a));
        check("busy_a",  64'(busy_a),  64'(e.busy_a));
        check("ready_b", 64'(ready_b), 64'(e.ready_b));
        check("busy_b",  64'(busy_b),  64'(e.busy_b));
      end
    end
  end

  initial begin : mon_out
    exp_o_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        check("regs_wreq_a0", 64'(wreq_a[0]), 64'(e.wa0));
        check("regs_wreq_b0", 64'(wreq_b[0]), 64'(e.wb0));
        check("regs_wreq_b1", 64'(wreq_b[1]), 64'(e.wb1));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    last_rdy_a = '0;
    req_valid  = '0;
    req_wreq   = '0;
    for (int i = 0; i < 2; i++) begin
      m_rr[i] = 1;
      for (int j = 0; j < N; j++) m_wait[i][j] = 0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_out_a",  64'(wreq_a[0]), 64'(0));
    check("reset_out_b0", 64'(wreq_b[0]), 64'(0));
    check("reset_out_b1", 64'(wreq_b[1]), 64'(0));
    check("reset_ready_a", 64'(ready_a), 64'(0));
    @(posedge clk);
    #2;
    step();
    rst = 1'b0;
    idle(1);

    // Reset mid-stream: a registered grant is wiped as soon as rst rises.
    req_valid   = 3'b001;
    req_wreq[0] = mk(1'b1, 5, 32'h11);
    step();
    step();
    rst = 1'b1;
    #1;
    check("async_rst_we_a", 64'(wreq_a[0].we), 64'(0));
    check("async_rst_we_b", 64'(wreq_b[0].we), 64'(0));
    step();
    rst = 1'b0;
    step();
    step();
    idle(1);

    // Pipe against mul/div with continuous demand.
    req_valid   = 3'b011;
    req_wreq[0] = mk(1'b1, 3, 32'hA0A0_0003);
    req_wreq[1] = mk(1'b1, 4, 32'hB1B1_0004);
    repeat (12) step();
    idle(1);

    // Round-robin between requesters 1 and 2.
    req_valid   = 3'b110;
    req_wreq[1] = mk(1'b1, 10, 32'h0000_1010);
    req_wreq[2] = mk(1'b1, 11, 32'h0000_2020);
    repeat (6) step();
    idle(1);

    // Null requests: consumed the same cycle, nothing written.
    req_valid   = 3'b011;
    req_wreq[0] = mk(1'b0, 6, 32'hDEAD_0006);
    req_wreq[1] = mk(1'b1, 0, 32'hDEAD_0000);
    step();
    idle(1);

    // Same destination register from two requesters.
    req_valid   = 3'b111;
    req_wreq[0] = mk(1'b1, 7, 32'h7000_0000);
    req_wreq[1] = mk(1'b1, 9, 32'h9000_0000);
    req_wreq[2] = mk(1'b1, 7, 32'h7000_0002);
    step();
    req_valid = 3'b100;
    step();
    idle(1);

    // Back-to-back pipe writes.
    for (int a = 1; a <= 8; a++) begin
      req_valid   = 3'b001;
      req_wreq[0] = mk(1'b1, a, $urandom());
      step();
    end
    idle(1);

    rand_cycles(600, 90);
    rand_cycles(600, 40);
    rand_cycles(600, 70);
    idle(3);

    check("comb_q_drained", 64'(comb_q.size()), 64'(0));
    check("out_q_drained",  64'(out_q.size()),  64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
